// File: rtl/axi_burst_master_if.sv
// AXI4 master-side signal bundle used by axi_burst_master.
// Carries the five AXI channels (AR, R, AW, W, B).
// The master modport is the bridge's view of the bus; the slave modport is the memory side.
interface axi_burst_master_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_W     = 32
) ();

  // Read address channel
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;

  // Read data channel
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  // Write address channel
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;

  // Write data channel
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wlast;

  // Write response channel
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast,
    output rready,
    output awvalid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast,
    input  rready,
    input  awvalid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp,
    input  bready
  );

endinterface

// File: rtl/axi_burst_master.sv
// Cache-line bridge: turns one core read/write-back request into a single
// AXI4 INCR burst of BLOCK_WIDTH/AXI_DATA_W beats, assembling or slicing the
// cache block, and pulses o_done (with o_resp_err) when the burst completes.
module axi_burst_master #(
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512,
  parameter int AXI_DATA_W  = 32
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_read_start,
  input  logic                   i_write_start,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic [BLOCK_WIDTH-1:0] i_data_block,
  output logic [BLOCK_WIDTH-1:0] o_data_block,
  output logic                   o_done,
  output logic                   o_resp_err,
  axi_burst_master_if.master     axi
);

  localparam int BEATS    = BLOCK_WIDTH / AXI_DATA_W;
  localparam int CNT_W    = $clog2(BEATS);
  localparam int OFFSET_W = $clog2(BLOCK_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    DONE
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [BLOCK_WIDTH-1:0] wblock_q;
  logic                   err_q;

  logic [ADDR_WIDTH-1:0]  addr_aligned;
  logic                   last_beat;
  logic                   addr_offset_unused;

  assign addr_aligned = {i_addr[ADDR_WIDTH-1:OFFSET_W], OFFSET_W'(0)};
  assign last_beat    = (cnt_q == LAST_BEAT);

  // Byte offset within the block is deliberately dropped.
  assign addr_offset_unused = ^i_addr[OFFSET_W-1:0];

  // Burst shape is fixed: one full cache block per transfer.
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'(BEATS - 1);
  assign axi.arsize  = 3'($clog2(AXI_DATA_W / 8));
  assign axi.arburst = 2'b01;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'(BEATS - 1);
  assign axi.awsize  = 3'($clog2(AXI_DATA_W / 8));
  assign axi.awburst = 2'b01;
  assign axi.wstrb   = '1;
  assign axi.wdata   = wblock_q[int'(cnt_q) * AXI_DATA_W +: AXI_DATA_W];

  // State register.
  always_ff @(posedge i_clk or posedge i_arst) begin
    // NOTE: sequential state always updates with <= so every flop samples pre-edge values.
    if (i_arst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.wlast   = 1'b0;
    axi.bready  = 1'b0;
    o_done      = 1'b0;
    o_resp_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_write_start)     state_d = WR_ADDR;
        else if (i_read_start) state_d = RD_ADDR;
      end
      RD_ADDR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        axi.rready = 1'b1;
        if (axi.rvalid && last_beat) state_d = DONE;
      end
      WR_ADDR: begin
        axi.awvalid = 1'b1;
        if (axi.awready) state_d = WR_DATA;
      end
      WR_DATA: begin
        axi.wvalid = 1'b1;
        axi.wlast  = last_beat;
        if (axi.wready && last_beat) state_d = WR_RESP;
      end
      WR_RESP: begin
        axi.bready = 1'b1;
        if (axi.bvalid) state_d = DONE;
      end
      DONE: begin
        o_done     = 1'b1;
        o_resp_err = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, beat counter, read-block assembly and error accumulation.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      cnt_q        <= '0;
      addr_q       <= '0;
      err_q        <= 1'b0;
      o_data_block <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (i_write_start || i_read_start) begin
            addr_q <= addr_aligned;
            err_q  <= 1'b0;
          end
        end
        RD_DATA: begin
          if (axi.rvalid) begin
            o_data_block[int'(cnt_q) * AXI_DATA_W +: AXI_DATA_W] <= axi.rdata;
            err_q <= err_q | (axi.rresp != 2'b00) | (axi.rlast != last_beat);
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WR_DATA: begin
          if (axi.wready) cnt_q <= cnt_q + 1'b1;
        end
        WR_RESP: begin
          if (axi.bvalid && (axi.bresp != 2'b00)) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Write-back block capture at request acceptance.
  always_ff @(posedge i_clk) begin
    // NOTE: this wide buffer has no reset; it is always loaded before any beat reads it.
    if (state_q == IDLE && i_write_start) wblock_q <= i_data_block;
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master: the bench acts as the AXI slave,
// randomises data, handshake delays and error injection, and compares against
// a transaction-level model of the expected block, beat sequence and error flag.
module tb_axi_burst_master;

  localparam int AW    = 64;
  localparam int BW    = 512;
  localparam int DW    = 32;
  localparam int BEATS = BW / DW;

  logic          clk = 1'b0;
  logic          arst;
  logic          read_start;
  logic          write_start;
  logic [AW-1:0] addr;
  logic [BW-1:0] data_in;
  logic [BW-1:0] data_out;
  logic          done;
  logic          resp_err;

  axi_burst_master_if #(.ADDR_WIDTH(AW), .DATA_W(DW)) axi ();

  axi_burst_master #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .AXI_DATA_W(DW)) dut (
    .i_clk         (clk),
    .i_arst        (arst),
    .i_read_start  (read_start),
    .i_write_start (write_start),
    .i_addr        (addr),
    .i_data_block  (data_in),
    .o_data_block  (data_out),
    .o_done        (done),
    .o_resp_err    (resp_err),
    .axi           (axi)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc;
  logic [BW-1:0] exp_rblock;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [AW-1:0] block_base(input logic [AW-1:0] a);
    return a - (a % (BW / 8));
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return {$urandom, $urandom};
  endfunction

  // Read burst: bench is the slave. bad_resp_beat / bad_last_beat < 0 means clean.
  task automatic run_read(input logic [AW-1:0] a, input int ar_wait, input int bad_resp_beat,
                          input int bad_last_beat, input bit gaps, input bit ramp, input bit check_lat);
    logic [DW-1:0] w [BEATS];
    logic [BW-1:0] blk;
    logic [AW-1:0] base;
    bit            exp_err;
    int            guard;
    int            idle;
    base    = block_base(a);
    exp_err = (bad_resp_beat >= 0) || (bad_last_beat >= 0);
    for (int k = 0; k < BEATS; k++) begin
      w[k] = ramp ? DW'(k) : $urandom;
      blk[k*DW +: DW] = w[k];
    end
    cyc        = 0;
    read_start = 1'b1;
    addr       = a;
    step();
    guard = 0;
    while (!axi.arvalid && guard < 50) begin
      step();
      guard++;
    end
    if (!axi.arvalid) begin
      check("rd_ar_timeout", 1'b0, 1'b1);
      read_start = 1'b0;
      return;
    end
    check("araddr", axi.araddr, base);
    check("ar_len_size_burst", {axi.arlen, axi.arsize, axi.arburst}, {8'd15, 3'd2, 2'b01});
    check("rd_no_aw", axi.awvalid, 1'b0);
    addr = rand_addr();
    for (int i = 0; i < ar_wait; i++) begin
      step();
      check("arvalid_hold", axi.arvalid, 1'b1);
      check("araddr_hold", axi.araddr, base);
    end
    axi.arready = 1'b1;
    step();
    axi.arready = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      idle = 0;
      while (gaps && idle < 3 && $urandom_range(0, 2) == 0) begin
        axi.rvalid = 1'b0;
        step();
        idle++;
      end
      check("rready", axi.rready, 1'b1);
      axi.rvalid = 1'b1;
      axi.rdata  = w[k];
      axi.rresp  = (k == bad_resp_beat) ? 2'b10 : 2'b00;
      axi.rlast  = (bad_last_beat >= 0) ? (k == bad_last_beat) : (k == BEATS - 1);
      step();
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rresp  = 2'b00;
    check("rd_done", done, 1'b1);
    check("rd_resp_err", resp_err, exp_err);
    if (check_lat) check("rd_latency", cyc, 18);
    exp_rblock = blk;
    check("rd_block", data_out, exp_rblock);
    read_start = 1'b0;
    step();
    check("rd_done_pulse", done, 1'b0);
    check("rd_block_hold", data_out, exp_rblock);
  endtask

  // Write burst. wr_mode: 0 always ready, 1 toggling, 2 random.
  task automatic run_write(input logic [AW-1:0] a, input int wr_mode, input int b_delay,
                           input logic [1:0] bresp, input bit also_read, input bit pattern);
    logic [DW-1:0] w [BEATS];
    logic [BW-1:0] blk;
    int            beat;
    int            guard;
    bit            rdy;
    for (int k = 0; k < BEATS; k++) begin
      w[k] = pattern ? (32'hA000_0000 + DW'(k)) : $urandom;
      blk[k*DW +: DW] = w[k];
    end
    cyc         = 0;
    write_start = 1'b1;
    read_start  = also_read;
    addr        = a;
    data_in     = blk;
    step();
    guard = 0;
    while (!axi.awvalid && guard < 50) begin
      step();
      guard++;
    end
    if (!axi.awvalid) begin
      check("wr_aw_timeout", 1'b0, 1'b1);
      write_start = 1'b0;
      read_start  = 1'b0;
      return;
    end
    check("awaddr", axi.awaddr, block_base(a));
    check("aw_len_size_burst", {axi.awlen, axi.awsize, axi.awburst}, {8'd15, 3'd2, 2'b01});
    check("aw_before_w", axi.wvalid, 1'b0);
    check("wr_no_ar", axi.arvalid, 1'b0);
    addr    = rand_addr();
    data_in = ~blk;
    axi.awready = 1'b1;
    step();
    axi.awready = 1'b0;
    beat  = 0;
    guard = 0;
    while (beat < BEATS && guard < 200) begin
      case (wr_mode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      check("wvalid", axi.wvalid, 1'b1);
      check("wdata", axi.wdata, w[beat]);
      check("wlast", axi.wlast, beat == BEATS - 1);
      check("wstrb", axi.wstrb, 4'hF);
      check("wr_no_ar_data", axi.arvalid, 1'b0);
      axi.wready = rdy;
      step();
      if (rdy) beat++;
      guard++;
    end
    axi.wready = 1'b0;
    if (beat < BEATS) check("wr_w_timeout", beat, BEATS);
    check("wr_wvalid_drop", axi.wvalid, 1'b0);
    check("bready", axi.bready, 1'b1);
    for (int d = 0; d < b_delay; d++) begin
      check("wr_done_early", done, 1'b0);
      step();
    end
    axi.bvalid = 1'b1;
    axi.bresp  = bresp;
    step();
    axi.bvalid = 1'b0;
    axi.bresp  = 2'b00;
    check("wr_done", done, 1'b1);
    check("wr_resp_err", resp_err, bresp != 2'b00);
    check("wr_block_hold", data_out, exp_rblock);
    write_start = 1'b0;
    read_start  = 1'b0;
    step();
    check("wr_done_pulse", done, 1'b0);
    check("wr_no_ar_after", axi.arvalid, 1'b0);
  endtask

  initial begin
    arst        = 1'b1;
    read_start  = 1'b0;
    write_start = 1'b0;
    addr        = '0;
    data_in     = '0;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    exp_rblock  = '0;
    cyc         = 0;
    step();
    step();
    check("rst_done", done, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_block", data_out, '0);
    check("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 5'b0);
    arst = 1'b0;
    step();

    // Zero-wait read, ramp data, latency check.
    run_read(64'h1234, 0, -1, -1, 1'b0, 1'b1, 1'b1);
    // Write with toggling wready, fixed pattern.
    run_write(64'h0000_0000_8000_0077, 1, 2, 2'b00, 1'b0, 1'b1);
    // Read and write requested together: write wins, no AR.
    run_write(rand_addr(), 0, 0, 2'b00, 1'b1, 1'b0);
    step();
    check("no_ar_after_dual", axi.arvalid, 1'b0);
    // Bad RRESP on beat 5, then a clean read clears the error.
    run_read(rand_addr(), 0, 5, -1, 1'b0, 1'b0, 1'b1);
    run_read(rand_addr(), 2, -1, -1, 1'b1, 1'b0, 1'b0);
    // Bad BRESP, then a clean write.
    run_write(rand_addr(), 2, 1, 2'b11, 1'b0, 1'b0);
    run_write(rand_addr(), 2, 3, 2'b00, 1'b0, 1'b0);
    // ARREADY held low for 10 cycles, early RLAST on beat 14.
    run_read(rand_addr(), 10, -1, 14, 1'b0, 1'b0, 1'b0);

    // Reset during beat 7 of a read.
    read_start = 1'b1;
    addr       = rand_addr();
    step();
    axi.arready = 1'b1;
    step();
    axi.arready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      axi.rvalid = 1'b1;
      axi.rdata  = $urandom;
      axi.rlast  = 1'b0;
      step();
    end
    check("pre_rst_rready", axi.rready, 1'b1);
    axi.rdata = $urandom;
    arst = 1'b1;
    #1;
    exp_rblock = '0;
    check("midrst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 5'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_block", data_out, exp_rblock);
    axi.rvalid = 1'b0;
    read_start = 1'b0;
    step();
    arst = 1'b0;
    step();
    run_read(rand_addr(), 0, -1, -1, 1'b0, 1'b0, 1'b1);

    // Randomised mix of transfers.
    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 1) == 1)
        run_read(rand_addr(), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, BEATS - 1) : -1,
                 -1, 1'b1, 1'b0, 1'b0);
      else
        run_write(rand_addr(), $urandom_range(0, 2), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0) ? 2'(1 + $urandom_range(0, 2)) : 2'b00,
                  1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
